// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the load/store unit
package lsu_pkg;

    // Access size as encoded on lsu_type_i
    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } lsu_type_e;

    // Access sequencer states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } lsu_state_e;

    localparam logic [3:0] SEL_ALL = 4'b1111;

    // A half must sit on an even address, a word on a multiple of four
    function automatic logic is_misaligned(input lsu_type_e acc_type, input logic [1:0] addr_lo);
        return ((acc_type == HALF) && addr_lo[0]) ||
               ((acc_type == WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane mask, load extraction and store merge datapath
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_type_e   acc_type,
    input  logic [1:0]  addr_lo,
    input  logic        sign_ext,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [3:0]  lane_mask,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [31:0] shifted;
    logic [31:0] repl;

    // Byte lanes touched by the access
    always_comb begin
        lane_mask = 4'b0000;
        case (acc_type)
            BYTE:    lane_mask = 4'b0001 << addr_lo;
            HALF:    lane_mask = 4'b0011 << addr_lo;
            WORD:    lane_mask = SEL_ALL;
            default: lane_mask = 4'b0000;
        endcase
    end

    // Shift the addressed lane down to bit 0 and extend it to 32 bits
    always_comb begin
        shifted   = mem_word >> {addr_lo, 3'b000};
        load_data = 32'h0;
        case (acc_type)
            BYTE:    load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            HALF:    load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            WORD:    load_data = shifted;
            default: load_data = 32'h0;
        endcase
    end

    // Replicate store data across lanes, then splice it into the old word where the mask is set
    always_comb begin
        repl = wdata;
        case (acc_type)
            BYTE:    repl = {4{wdata[7:0]}};
            HALF:    repl = {2{wdata[15:0]}};
            default: repl = wdata;
        endcase
        for (int i = 0; i < 4; i++) begin
            store_word[8*i +: 8] = lane_mask[i] ? repl[8*i +: 8] : mem_word[8*i +: 8];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store sequencer between execute stage and data RAM
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DMEM_DEPTH = 2048
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_busy_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        data_ce_o,
    output logic        data_we_o,
    output logic [3:0]  data_sel_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    input  logic        data_rvalid_i
);

    localparam logic [31:0] DEPTH_W = 32'(DMEM_DEPTH);

    lsu_state_e  state_q, state_d;

    logic        req_we_q;
    lsu_type_e   req_type_q;
    logic        req_sign_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;
    logic [31:0] mem_word_q;

    lsu_type_e   in_type;
    logic        can_accept;
    logic        accept;
    logic        out_of_range;
    logic        req_bad;

    logic [3:0]  lane_mask;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign in_type      = lsu_type_e'(lsu_type_i);
    assign can_accept   = (state_q == IDLE) || (state_q == RESP) || (state_q == ERR);
    assign accept       = can_accept && lsu_req_i;
    assign out_of_range = {2'b00, lsu_addr_i[31:2]} >= DEPTH_W;
    assign req_bad      = (in_type == ILLEGAL) || is_misaligned(in_type, lsu_addr_i[1:0]) || out_of_range;

    lsu_align u_align (
        .acc_type   (req_type_q),
        .addr_lo    (req_addr_q[1:0]),
        .sign_ext   (req_sign_q),
        .mem_word   (mem_word_q),
        .wdata      (req_wdata_q),
        .lane_mask  (lane_mask),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // State register; reset aborts any access in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the request fields on acceptance so the requester can move on
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_we_q    <= 1'b0;
            req_type_q  <= BYTE;
            req_sign_q  <= 1'b0;
            req_addr_q  <= 32'h0;
            req_wdata_q <= 32'h0;
        end else if (accept) begin
            req_we_q    <= lsu_we_i;
            req_type_q  <= in_type;
            req_sign_q  <= lsu_sign_ext_i;
            req_addr_q  <= lsu_addr_i;
            req_wdata_q <= lsu_wdata_i;
        end
    end

    // Capture the RAM word once the read completes (feeds both load extraction and RMW merge)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_word_q <= 32'h0;
        end else if ((state_q == RD) && data_rvalid_i) begin
            mem_word_q <= data_rdata_i;
        end
    end

    // Next-state decode and state-driven outputs; everything idles at zero
    always_comb begin
        state_d      = state_q;
        lsu_busy_o   = 1'b0;
        lsu_rvalid_o = 1'b0;
        lsu_rdata_o  = 32'h0;
        lsu_err_o    = 1'b0;
        data_ce_o    = 1'b0;
        data_we_o    = 1'b0;
        data_sel_o   = 4'b0000;
        data_addr_o  = 32'h0;
        data_wdata_o = 32'h0;

        case (state_q)
            IDLE, RESP, ERR: begin
                if (state_q == RESP) begin
                    lsu_rvalid_o = 1'b1;
                    lsu_rdata_o  = req_we_q ? 32'h0 : load_data;
                end
                if (state_q == ERR) begin
                    lsu_err_o = 1'b1;
                end
                if (lsu_req_i) begin
                    if (req_bad) begin
                        state_d = ERR;
                    end else if (lsu_we_i && (in_type == WORD)) begin
                        state_d = WR;
                    end else begin
                        // Loads and sub-word stores both start with a read
                        state_d = RD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                lsu_busy_o  = 1'b1;
                data_ce_o   = 1'b1;
                data_sel_o  = lane_mask;
                data_addr_o = {req_addr_q[31:2], 2'b00};
                if (data_rvalid_i) begin
                    state_d = req_we_q ? WR : RESP;
                end
            end
            WR: begin
                lsu_busy_o   = 1'b1;
                data_ce_o    = 1'b1;
                data_we_o    = 1'b1;
                data_sel_o   = SEL_ALL;
                data_addr_o  = {req_addr_q[31:2], 2'b00};
                data_wdata_o = store_word;
                state_d      = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
